// File: rtl/cmd_queue_axi_reg_bridge_mc_if.sv
// AXI4-Lite subordinate bundle plus register-request bundle for every channel of the bridge.
// Vectors are channel-major with channel 0 in the LSBs.
interface cmd_queue_axi_reg_bridge_mc_if #(
  parameter int unsigned C_NUM_CH     = 2,
  parameter int unsigned C_ADDR_WIDTH = 12,
  parameter int unsigned C_DATA_WIDTH = 32
);
  localparam int unsigned N = C_NUM_CH;
  localparam int unsigned A = C_ADDR_WIDTH;
  localparam int unsigned D = C_DATA_WIDTH;
  localparam int unsigned S = C_DATA_WIDTH / 8;

  logic [N-1:0]   s_axi_awvalid;
  logic [N-1:0]   s_axi_awready;
  logic [N*A-1:0] s_axi_awaddr;
  logic [N-1:0]   s_axi_wvalid;
  logic [N-1:0]   s_axi_wready;
  logic [N*D-1:0] s_axi_wdata;
  logic [N*S-1:0] s_axi_wstrb;
  logic [N-1:0]   s_axi_bvalid;
  logic [N-1:0]   s_axi_bready;
  logic [N*2-1:0] s_axi_bresp;
  logic [N-1:0]   s_axi_arvalid;
  logic [N-1:0]   s_axi_arready;
  logic [N*A-1:0] s_axi_araddr;
  logic [N-1:0]   s_axi_rvalid;
  logic [N-1:0]   s_axi_rready;
  logic [N*D-1:0] s_axi_rdata;
  logic [N*2-1:0] s_axi_rresp;

  logic [N-1:0]   reg_wr_valid;
  logic [N*A-1:0] reg_wr_addr;
  logic [N*D-1:0] reg_wr_data;
  logic [N*S-1:0] reg_wr_be;
  logic [N-1:0]   reg_wr_done;
  logic [N*2-1:0] reg_wr_resp;
  logic [N-1:0]   reg_rd_valid;
  logic [N*A-1:0] reg_rd_addr;
  logic [N-1:0]   reg_rd_done;
  logic [N*2-1:0] reg_rd_resp;
  logic [N*D-1:0] reg_rd_data;

  // Bridge side
  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_bready,
           s_axi_arvalid, s_axi_araddr, s_axi_rready,
           reg_wr_done, reg_wr_resp, reg_rd_done, reg_rd_resp, reg_rd_data,
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
           s_axi_rvalid, s_axi_rdata, s_axi_rresp,
           reg_wr_valid, reg_wr_addr, reg_wr_data, reg_wr_be, reg_rd_valid, reg_rd_addr
  );

  // Interconnect / register-file side
  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_bready,
           s_axi_arvalid, s_axi_araddr, s_axi_rready,
           reg_wr_done, reg_wr_resp, reg_rd_done, reg_rd_resp, reg_rd_data,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
           s_axi_rvalid, s_axi_rdata, s_axi_rresp,
           reg_wr_valid, reg_wr_addr, reg_wr_data, reg_wr_be, reg_rd_valid, reg_rd_addr
  );
endinterface

// File: rtl/cmd_queue_axi_reg_bridge_mc.sv
// N-channel AXI4-Lite to register-interface bridge: one independent engine per channel with
// round-robin read/write arbitration and a per-access timeout that forces an SLVERR completion.
module cmd_queue_axi_reg_bridge_mc #(
  parameter int unsigned C_NUM_CH     = 2,
  parameter int unsigned C_ADDR_WIDTH = 12,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT    = 256
) (
  input  logic                          aclk,
  input  logic                          areset,
  cmd_queue_axi_reg_bridge_mc_if.slave  bus
);
  localparam int unsigned A  = C_ADDR_WIDTH;
  localparam int unsigned D  = C_DATA_WIDTH;
  localparam int unsigned S  = C_DATA_WIDTH / 8;
  localparam int unsigned CW = $clog2(C_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST    = CW'(C_TIMEOUT - 1);
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  // Complete per-channel register set; all-zero is the reset value (rr_rd=0 means write preferred).
  typedef struct packed {
    state_t          state;
    logic            aw_cap;
    logic            w_cap;
    logic            ar_cap;
    logic            rr_rd;
    logic [A-1:0]    awaddr;
    logic [D-1:0]    wdata;
    logic [S-1:0]    wstrb;
    logic [A-1:0]    araddr;
    logic [CW-1:0]   cnt;
    logic            awready;
    logic            wready;
    logic            arready;
    logic            bvalid;
    logic [1:0]      bresp;
    logic            rvalid;
    logic [1:0]      rresp;
    logic [D-1:0]    rdata;
    logic            wr_valid;
    logic [A-1:0]    wr_addr;
    logic [D-1:0]    wr_data;
    logic [S-1:0]    wr_be;
    logic            rd_valid;
    logic [A-1:0]    rd_addr;
  } ch_regs_t;

  for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
    ch_regs_t r_ch;
    ch_regs_t w_ch_n;
    logic     w_aw_hs;
    logic     w_w_hs;
    logic     w_ar_hs;
    logic     w_wr_go;
    logic     w_rd_go;

    assign w_aw_hs = bus.s_axi_awvalid[g] & r_ch.awready;
    assign w_w_hs  = bus.s_axi_wvalid[g]  & r_ch.wready;
    assign w_ar_hs = bus.s_axi_arvalid[g] & r_ch.arready;

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        r_ch <= '0;
      end else begin
        r_ch <= w_ch_n;
      end
    end

    always_comb begin
      w_ch_n          = r_ch;
      w_ch_n.wr_valid = 1'b0;
      w_ch_n.rd_valid = 1'b0;
      w_wr_go         = 1'b0;
      w_rd_go         = 1'b0;
      case (r_ch.state)
        IDLE: begin
          if (w_aw_hs) begin
            w_ch_n.aw_cap = 1'b1;
            w_ch_n.awaddr = bus.s_axi_awaddr[g*A +: A];
          end
          if (w_w_hs) begin
            w_ch_n.w_cap = 1'b1;
            w_ch_n.wdata = bus.s_axi_wdata[g*D +: D];
            w_ch_n.wstrb = bus.s_axi_wstrb[g*S +: S];
          end
          if (w_ar_hs) begin
            w_ch_n.ar_cap = 1'b1;
            w_ch_n.araddr = bus.s_axi_araddr[g*A +: A];
          end
          // Beats captured this very cycle count, so accept-to-strobe latency is one cycle.
          w_wr_go = w_ch_n.aw_cap & w_ch_n.w_cap & (~w_ch_n.ar_cap | ~r_ch.rr_rd);
          w_rd_go = w_ch_n.ar_cap & ~w_wr_go;
          if (w_wr_go) begin
            w_ch_n.state    = WR_REQ;
            w_ch_n.wr_valid = 1'b1;
            w_ch_n.wr_addr  = w_ch_n.awaddr;
            w_ch_n.wr_data  = w_ch_n.wdata;
            w_ch_n.wr_be    = w_ch_n.wstrb;
            w_ch_n.aw_cap   = 1'b0;
            w_ch_n.w_cap    = 1'b0;
            w_ch_n.rr_rd    = 1'b1;
            w_ch_n.cnt      = '0;
          end else if (w_rd_go) begin
            w_ch_n.state    = RD_REQ;
            w_ch_n.rd_valid = 1'b1;
            w_ch_n.rd_addr  = w_ch_n.araddr;
            w_ch_n.ar_cap   = 1'b0;
            w_ch_n.rr_rd    = 1'b0;
            w_ch_n.cnt      = '0;
          end
        end
        WR_REQ: begin
          if (bus.reg_wr_done[g]) begin
            w_ch_n.state  = WR_RESP;
            w_ch_n.bvalid = 1'b1;
            w_ch_n.bresp  = bus.reg_wr_resp[g*2 +: 2];
          end else if (r_ch.cnt == CNT_LAST) begin
            w_ch_n.state  = WR_RESP;
            w_ch_n.bvalid = 1'b1;
            w_ch_n.bresp  = RESP_SLVERR;
          end else begin
            w_ch_n.cnt = r_ch.cnt + 1'b1;
          end
        end
        WR_RESP: begin
          if (bus.s_axi_bready[g]) begin
            w_ch_n.state  = IDLE;
            w_ch_n.bvalid = 1'b0;
          end
        end
        RD_REQ: begin
          if (bus.reg_rd_done[g]) begin
            w_ch_n.state  = RD_RESP;
            w_ch_n.rvalid = 1'b1;
            w_ch_n.rresp  = bus.reg_rd_resp[g*2 +: 2];
            w_ch_n.rdata  = bus.reg_rd_data[g*D +: D];
          end else if (r_ch.cnt == CNT_LAST) begin
            w_ch_n.state  = RD_RESP;
            w_ch_n.rvalid = 1'b1;
            w_ch_n.rresp  = RESP_SLVERR;
            w_ch_n.rdata  = '0;
          end else begin
            w_ch_n.cnt = r_ch.cnt + 1'b1;
          end
        end
        RD_RESP: begin
          if (bus.s_axi_rready[g]) begin
            w_ch_n.state  = IDLE;
            w_ch_n.rvalid = 1'b0;
          end
        end
        default: w_ch_n.state = IDLE;
      endcase
      // Readies are registered, so they are derived from the state the channel is about to enter.
      w_ch_n.awready = (w_ch_n.state == IDLE) & ~w_ch_n.aw_cap;
      w_ch_n.wready  = (w_ch_n.state == IDLE) & ~w_ch_n.w_cap;
      w_ch_n.arready = (w_ch_n.state == IDLE) & ~w_ch_n.aw_cap & ~w_ch_n.w_cap & ~w_ch_n.ar_cap;
    end

    assign bus.s_axi_awready[g]         = r_ch.awready;
    assign bus.s_axi_wready[g]          = r_ch.wready;
    assign bus.s_axi_arready[g]         = r_ch.arready;
    assign bus.s_axi_bvalid[g]          = r_ch.bvalid;
    assign bus.s_axi_bresp[g*2 +: 2]    = r_ch.bresp;
    assign bus.s_axi_rvalid[g]          = r_ch.rvalid;
    assign bus.s_axi_rresp[g*2 +: 2]    = r_ch.rresp;
    assign bus.s_axi_rdata[g*D +: D]    = r_ch.rdata;
    assign bus.reg_wr_valid[g]          = r_ch.wr_valid;
    assign bus.reg_wr_addr[g*A +: A]    = r_ch.wr_addr;
    assign bus.reg_wr_data[g*D +: D]    = r_ch.wr_data;
    assign bus.reg_wr_be[g*S +: S]      = r_ch.wr_be;
    assign bus.reg_rd_valid[g]          = r_ch.rd_valid;
    assign bus.reg_rd_addr[g*A +: A]    = r_ch.rd_addr;
  end
endmodule

// File: tb/tb_cmd_queue_axi_reg_bridge_mc.sv
// Directed bench for the multi-channel AXI-Lite register bridge, checked every cycle against a
// transaction-level model plus literal expectations for the key scenarios.
module tb_cmd_queue_axi_reg_bridge_mc;
  localparam int unsigned N = 2;
  localparam int unsigned A = 12;
  localparam int unsigned D = 32;
  localparam int unsigned S = 4;
  localparam int          T = 16;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  cmd_queue_axi_reg_bridge_mc_if #(.C_NUM_CH(N), .C_ADDR_WIDTH(A), .C_DATA_WIDTH(D)) bus ();

  cmd_queue_axi_reg_bridge_mc #(
    .C_NUM_CH(N), .C_ADDR_WIDTH(A), .C_DATA_WIDTH(D), .C_TIMEOUT(T)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  int total;
  int bad;

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s ch%0d actual=%0h expected=%0h t=%0t", nm, c, act, exp, $time);
    end
  endtask

  // Model: each channel is idle, waiting on the register file (write/read), or holding an answer.
  localparam int M_IDLE = 0, M_WR = 1, M_WANS = 2, M_RD = 3, M_RANS = 4;
  int             m_mode[N];
  bit             m_aw[N], m_w[N], m_ar[N], m_read_next[N];
  int             m_deadline[N];
  int             cyc;
  logic [A-1:0]   m_awaddr[N], m_araddr[N];
  logic [D-1:0]   m_wdata[N];
  logic [S-1:0]   m_wstrb[N];
  bit             e_awready[N], e_wready[N], e_arready[N], e_bvalid[N], e_rvalid[N], e_wrv[N], e_rdv[N];
  logic [1:0]     e_bresp[N], e_rresp[N];
  logic [D-1:0]   e_rdata[N], e_wr_data[N];
  logic [A-1:0]   e_wr_addr[N], e_rd_addr[N];
  logic [S-1:0]   e_wr_be[N];

  task automatic model_reset();
    for (int c = 0; c < int'(N); c++) begin
      m_mode[c] = M_IDLE; m_aw[c] = 0; m_w[c] = 0; m_ar[c] = 0; m_read_next[c] = 0;
      m_awaddr[c] = '0; m_araddr[c] = '0; m_wdata[c] = '0; m_wstrb[c] = '0; m_deadline[c] = 0;
      e_awready[c] = 0; e_wready[c] = 0; e_arready[c] = 0; e_bvalid[c] = 0; e_rvalid[c] = 0;
      e_wrv[c] = 0; e_rdv[c] = 0; e_bresp[c] = '0; e_rresp[c] = '0; e_rdata[c] = '0;
      e_wr_data[c] = '0; e_wr_addr[c] = '0; e_rd_addr[c] = '0; e_wr_be[c] = '0;
    end
  endtask

  // Advance the model by one clock edge using the inputs that edge will see.
  task automatic model_step();
    for (int c = 0; c < int'(N); c++) begin
      bit aw_hs, w_hs, ar_hs, want_wr, want_rd;
      aw_hs = bus.s_axi_awvalid[c] && e_awready[c];
      w_hs  = bus.s_axi_wvalid[c]  && e_wready[c];
      ar_hs = bus.s_axi_arvalid[c] && e_arready[c];
      e_wrv[c] = 0;
      e_rdv[c] = 0;
      case (m_mode[c])
        M_IDLE: begin
          if (aw_hs) begin m_aw[c] = 1; m_awaddr[c] = bus.s_axi_awaddr[c*A +: A]; end
          if (w_hs)  begin m_w[c] = 1; m_wdata[c] = bus.s_axi_wdata[c*D +: D]; m_wstrb[c] = bus.s_axi_wstrb[c*S +: S]; end
          if (ar_hs) begin m_ar[c] = 1; m_araddr[c] = bus.s_axi_araddr[c*A +: A]; end
          want_wr = m_aw[c] && m_w[c];
          want_rd = m_ar[c];
          if (want_wr && (!want_rd || !m_read_next[c])) begin
            m_mode[c] = M_WR; e_wrv[c] = 1;
            e_wr_addr[c] = m_awaddr[c]; e_wr_data[c] = m_wdata[c]; e_wr_be[c] = m_wstrb[c];
            m_aw[c] = 0; m_w[c] = 0; m_read_next[c] = 1; m_deadline[c] = cyc + T;
          end else if (want_rd) begin
            m_mode[c] = M_RD; e_rdv[c] = 1; e_rd_addr[c] = m_araddr[c];
            m_ar[c] = 0; m_read_next[c] = 0; m_deadline[c] = cyc + T;
          end
        end
        M_WR: begin
          if (bus.reg_wr_done[c]) begin
            m_mode[c] = M_WANS; e_bvalid[c] = 1; e_bresp[c] = bus.reg_wr_resp[c*2 +: 2];
          end else if (cyc == m_deadline[c]) begin
            m_mode[c] = M_WANS; e_bvalid[c] = 1; e_bresp[c] = 2'b10;
          end
        end
        M_WANS: if (bus.s_axi_bready[c]) begin m_mode[c] = M_IDLE; e_bvalid[c] = 0; end
        M_RD: begin
          if (bus.reg_rd_done[c]) begin
            m_mode[c] = M_RANS; e_rvalid[c] = 1;
            e_rresp[c] = bus.reg_rd_resp[c*2 +: 2]; e_rdata[c] = bus.reg_rd_data[c*D +: D];
          end else if (cyc == m_deadline[c]) begin
            m_mode[c] = M_RANS; e_rvalid[c] = 1; e_rresp[c] = 2'b10; e_rdata[c] = '0;
          end
        end
        M_RANS: if (bus.s_axi_rready[c]) begin m_mode[c] = M_IDLE; e_rvalid[c] = 0; end
        default: m_mode[c] = M_IDLE;
      endcase
      e_awready[c] = (m_mode[c] == M_IDLE) && !m_aw[c];
      e_wready[c]  = (m_mode[c] == M_IDLE) && !m_w[c];
      e_arready[c] = (m_mode[c] == M_IDLE) && !m_aw[c] && !m_w[c] && !m_ar[c];
    end
    cyc++;
  endtask

  always @(negedge aclk) begin
    if (areset) model_reset();
    for (int c = 0; c < int'(N); c++) begin
      chk("awready",  c, 64'(bus.s_axi_awready[c]), 64'(e_awready[c]));
      chk("wready",   c, 64'(bus.s_axi_wready[c]),  64'(e_wready[c]));
      chk("arready",  c, 64'(bus.s_axi_arready[c]), 64'(e_arready[c]));
      chk("bvalid",   c, 64'(bus.s_axi_bvalid[c]),  64'(e_bvalid[c]));
      chk("bresp",    c, 64'(bus.s_axi_bresp[c*2 +: 2]), 64'(e_bresp[c]));
      chk("rvalid",   c, 64'(bus.s_axi_rvalid[c]),  64'(e_rvalid[c]));
      chk("rresp",    c, 64'(bus.s_axi_rresp[c*2 +: 2]), 64'(e_rresp[c]));
      chk("rdata",    c, 64'(bus.s_axi_rdata[c*D +: D]), 64'(e_rdata[c]));
      chk("wr_valid", c, 64'(bus.reg_wr_valid[c]),  64'(e_wrv[c]));
      chk("wr_addr",  c, 64'(bus.reg_wr_addr[c*A +: A]), 64'(e_wr_addr[c]));
      chk("wr_data",  c, 64'(bus.reg_wr_data[c*D +: D]), 64'(e_wr_data[c]));
      chk("wr_be",    c, 64'(bus.reg_wr_be[c*S +: S]), 64'(e_wr_be[c]));
      chk("rd_valid", c, 64'(bus.reg_rd_valid[c]),  64'(e_rdv[c]));
      chk("rd_addr",  c, 64'(bus.reg_rd_addr[c*A +: A]), 64'(e_rd_addr[c]));
    end
    if (!areset) model_step();
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic put_aw(input int c, input logic [A-1:0] a);
    bus.s_axi_awaddr[c*A +: A] = a; bus.s_axi_awvalid[c] = 1'b1;
  endtask
  task automatic put_w(input int c, input logic [D-1:0] d, input logic [S-1:0] s);
    bus.s_axi_wdata[c*D +: D] = d; bus.s_axi_wstrb[c*S +: S] = s; bus.s_axi_wvalid[c] = 1'b1;
  endtask
  task automatic put_ar(input int c, input logic [A-1:0] a);
    bus.s_axi_araddr[c*A +: A] = a; bus.s_axi_arvalid[c] = 1'b1;
  endtask
  task automatic drop(input int c);
    bus.s_axi_awvalid[c] = 1'b0; bus.s_axi_wvalid[c] = 1'b0; bus.s_axi_arvalid[c] = 1'b0;
  endtask
  task automatic wdone(input int c, input logic [1:0] r);
    bus.reg_wr_done[c] = 1'b1; bus.reg_wr_resp[c*2 +: 2] = r;
    tick();
    bus.reg_wr_done[c] = 1'b0; bus.reg_wr_resp[c*2 +: 2] = 2'b00;
  endtask
  task automatic rdone(input int c, input logic [1:0] r, input logic [D-1:0] d);
    bus.reg_rd_done[c] = 1'b1; bus.reg_rd_resp[c*2 +: 2] = r; bus.reg_rd_data[c*D +: D] = d;
    tick();
    bus.reg_rd_done[c] = 1'b0; bus.reg_rd_resp[c*2 +: 2] = 2'b00; bus.reg_rd_data[c*D +: D] = '0;
  endtask
  task automatic wait_wr(input int c);
    for (int n = 0; n < 20 && !bus.reg_wr_valid[c]; n++) tick();
    chk("wait_wr_strobe", c, 64'(bus.reg_wr_valid[c]), 64'd1);
  endtask
  task automatic wait_rd(input int c);
    for (int n = 0; n < 20 && !bus.reg_rd_valid[c]; n++) tick();
    chk("wait_rd_strobe", c, 64'(bus.reg_rd_valid[c]), 64'd1);
  endtask

  initial begin
    int n;
    total = 0; bad = 0; cyc = 0;
    areset = 1'b1;
    bus.s_axi_awvalid = '0; bus.s_axi_awaddr = '0; bus.s_axi_wvalid = '0; bus.s_axi_wdata = '0;
    bus.s_axi_wstrb = '0; bus.s_axi_arvalid = '0; bus.s_axi_araddr = '0;
    bus.s_axi_bready = '1; bus.s_axi_rready = '1;
    bus.reg_wr_done = '0; bus.reg_wr_resp = '0; bus.reg_rd_done = '0; bus.reg_rd_resp = '0;
    bus.reg_rd_data = '0;
    repeat (3) tick();
    chk("rst_awready", 0, 64'(bus.s_axi_awready), 64'd0);
    chk("rst_rdata",   0, 64'(bus.s_axi_rdata), 64'd0);
    areset = 1'b0;
    tick();
    chk("idle_ready", 0, 64'(bus.s_axi_arready), 64'h3);

    // Single write on ch0, AW and W together, done three cycles after the strobe.
    put_aw(0, 12'h010); put_w(0, 32'hA5A5A5A5, 4'hF);
    tick(); drop(0);
    chk("t1_strobe", 0, 64'(bus.reg_wr_valid[0]), 64'd1);
    chk("t1_addr",   0, 64'(bus.reg_wr_addr[11:0]), 64'h010);
    tick(); tick();
    wdone(0, 2'b00);
    chk("t1_bvalid", 0, 64'(bus.s_axi_bvalid[0]), 64'd1);
    chk("t1_bresp",  0, 64'(bus.s_axi_bresp[1:0]), 64'd0);
    tick();

    // ch1: W five cycles ahead of AW, then a read.
    put_w(1, 32'h11112222, 4'h3);
    tick(); drop(1);
    repeat (4) tick();
    put_aw(1, 12'h024);
    tick(); drop(1);
    chk("t2_strobe", 1, 64'(bus.reg_wr_valid[1]), 64'd1);
    chk("t2_be",     1, 64'(bus.reg_wr_be[7:4]), 64'h3);
    wdone(1, 2'b00);
    tick();
    put_ar(1, 12'h020);
    tick(); drop(1);
    chk("t2_rd_addr", 1, 64'(bus.reg_rd_addr[23:12]), 64'h020);
    rdone(1, 2'b00, 32'h12345678);
    chk("t2_rdata", 1, 64'(bus.s_axi_rdata[63:32]), 64'h12345678);
    tick();

    // Read timeout on ch0; a done pulse during the forced answer must be ignored.
    put_ar(0, 12'h030);
    tick(); drop(0);
    n = 0;
    while (!bus.s_axi_rvalid[0] && n < 40) begin tick(); n++; end
    chk("t3_latency", 0, 64'(n), 64'd16);
    chk("t3_rresp",   0, 64'(bus.s_axi_rresp[1:0]), 64'h2);
    rdone(0, 2'b00, 32'hDEADBEEF);
    chk("t3_late_done_rvalid", 0, 64'(bus.s_axi_rvalid[0]), 64'd0);
    chk("t3_late_done_rdata",  0, 64'(bus.s_axi_rdata[31:0]), 64'd0);

    // Arbitration from reset: write wins, then read; a lone write then makes the read win.
    areset = 1'b1; tick(); tick(); areset = 1'b0; tick();
    put_aw(0, 12'h100); put_w(0, 32'h0000BEEF, 4'hC); put_ar(0, 12'h104);
    tick(); drop(0);
    chk("t4_wr_first", 0, 64'(bus.reg_wr_valid[0]), 64'd1);
    chk("t4_rd_later", 0, 64'(bus.reg_rd_valid[0]), 64'd0);
    tick(); wdone(0, 2'b00); tick();
    wait_rd(0);
    tick(); rdone(0, 2'b00, 32'h00000055); tick();
    put_aw(0, 12'h108); put_w(0, 32'h1, 4'h1);
    tick(); drop(0); tick(); wdone(0, 2'b00); tick();
    put_aw(0, 12'h10C); put_w(0, 32'h2, 4'h2); put_ar(0, 12'h110);
    tick(); drop(0);
    chk("t4_rd_first", 0, 64'(bus.reg_rd_valid[0]), 64'd1);
    chk("t4_wr_later", 0, 64'(bus.reg_wr_valid[0]), 64'd0);
    tick(); rdone(0, 2'b01, 32'h77); tick();
    wait_wr(0);
    tick(); wdone(0, 2'b00); tick();

    // Backpressure on B with a new zero-strobe write waiting.
    bus.s_axi_bready[0] = 1'b0;
    put_aw(0, 12'h040); put_w(0, 32'hCAFEF00D, 4'h5);
    tick(); drop(0); tick();
    wdone(0, 2'b11);
    put_aw(0, 12'h044); put_w(0, 32'h0BADF00D, 4'h0);
    for (int i = 0; i < 10; i++) begin
      chk("t5_bvalid_held", 0, 64'(bus.s_axi_bvalid[0]), 64'd1);
      chk("t5_no_strobe",   0, 64'(bus.reg_wr_valid[0]), 64'd0);
      tick();
    end
    chk("t5_bresp_held", 0, 64'(bus.s_axi_bresp[1:0]), 64'h3);
    bus.s_axi_bready[0] = 1'b1;
    tick(); tick(); drop(0);
    chk("t5_zero_be", 0, 64'(bus.reg_wr_be[3:0]), 64'h0);
    chk("t5_addr",    0, 64'(bus.reg_wr_addr[11:0]), 64'h044);
    tick(); wdone(0, 2'b00); tick();

    // Concurrent ch0 write and ch1 read, then reset while both wait on the register file.
    put_aw(0, 12'h0F0); put_w(0, 32'h600DF00D, 4'hF); put_ar(1, 12'h0F4);
    tick(); drop(0); drop(1);
    chk("t6_both_strobes", 0, 64'({bus.reg_rd_valid[1], bus.reg_wr_valid[0]}), 64'h3);
    tick();
    areset = 1'b1;
    #1;
    chk("t6_rst_rd_addr", 1, 64'(bus.reg_rd_addr[23:12]), 64'd0);
    chk("t6_rst_wr_addr", 0, 64'(bus.reg_wr_addr[11:0]), 64'd0);
    tick(); tick();
    areset = 1'b0;
    repeat (20) tick();
    chk("t6_no_rvalid", 1, 64'(bus.s_axi_rvalid[1]), 64'd0);
    chk("t6_idle",      1, 64'(bus.s_axi_arready[1]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
